// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core slice: instruction memory geometry and
// the state encoding of the instruction-memory loader.
package mips_pkg;

  localparam int INST_DEPTH_LOG2 = 8;

  localparam logic [1:0] LDR_LEN  = 2'd0;
  localparam logic [1:0] LDR_DATA = 2'd1;
  localparam logic [1:0] LDR_DONE = 2'd2;
  localparam logic [1:0] LDR_ERR  = 2'd3;

  typedef enum logic [1:0] {
    ST_LEN  = LDR_LEN,
    ST_DATA = LDR_DATA,
    ST_DONE = LDR_DONE,
    ST_ERR  = LDR_ERR
  } ldr_state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs four bytes, most significant first, into a 32-bit word. word_valid and
// word_out are combinational on the 4th byte so the caller can register them.
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [31:0] word_out,
  output logic        word_valid
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  assign word_valid = byte_valid && !clear && (cnt_q == 2'd3);
  assign word_out   = {shift_q, byte_in};

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_valid) begin
      shift_q <= {shift_q[15:0], byte_in};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Loads a length-prefixed big-endian program from a UART byte stream into the
// instruction RAM and holds the CPU in reset until the load has completed.
module inst_mem_loader
  import mips_pkg::*;
#(
  parameter int DEPTH_LOG2     = INST_DEPTH_LOG2,
  parameter int TIMEOUT_CYCLES = 100000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        reload,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam int          IDX_W     = DEPTH_LOG2 + 1;
  localparam int          TO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] MAX_WORDS = 32'(1) << DEPTH_LOG2;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  ldr_state_t       state, state_next;
  logic [IDX_W-1:0] word_idx, n_words;
  logic [TO_W-1:0]  to_cnt;
  logic             started;
  logic             accept, asm_clear, counting, timed_out;
  logic [31:0]      word_out;
  logic             word_valid;

  // Bytes arriving after the last word of the frame are dropped, not assembled.
  assign accept    = rx_valid && !reload &&
                     (state == ST_LEN || (state == ST_DATA && word_idx != n_words));
  assign asm_clear = reload || state == ST_DONE || state == ST_ERR;
  assign counting  = (state == ST_LEN && started) || state == ST_DATA;
  assign timed_out = counting && !rx_valid && to_cnt == TO_LAST;

  word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (asm_clear),
    .byte_in    (rx_data),
    .byte_valid (accept),
    .word_out   (word_out),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_LEN;
    else       state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    if (reload) begin
      state_next = ST_LEN;
    end else begin
      case (state)
        ST_LEN: begin
          if (word_valid) begin
            if (word_out == 32'd0)          state_next = ST_DONE;
            else if (word_out > MAX_WORDS)  state_next = ST_ERR;
            else                            state_next = ST_DATA;
          end else if (timed_out) begin
            state_next = ST_ERR;
          end
        end
        ST_DATA: begin
          if (word_idx == n_words) state_next = ST_DONE;
          else if (timed_out)      state_next = ST_ERR;
        end
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_idx  <= '0;
      n_words   <= '0;
      started   <= 1'b0;
      to_cnt    <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cpu_hold  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      cpu_hold  <= (state_next != ST_DONE);
      load_done <= (state_next == ST_DONE);
      load_err  <= (state_next == ST_ERR);
      if (reload) begin
        word_idx <= '0;
        n_words  <= '0;
        started  <= 1'b0;
        to_cnt   <= '0;
      end else begin
        if (rx_valid || !counting) to_cnt <= '0;
        else                       to_cnt <= to_cnt + 1'b1;

        if (state == ST_LEN && accept) started <= 1'b1;

        if (state == ST_LEN && word_valid) begin
          n_words  <= word_out[IDX_W-1:0];
          word_idx <= '0;
          started  <= 1'b0;
        end

        // The write strobe is registered, so a reload arriving next cycle
        // cannot cancel a word that has already been assembled.
        if (state == ST_DATA && word_valid) begin
          wr_en    <= 1'b1;
          wr_addr  <= 32'({word_idx[DEPTH_LOG2-1:0], 2'b00});
          wr_data  <= word_out;
          word_idx <= word_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: a per-cycle vector table for the
// frame-level flows plus directed sequences for timeout, streaming and reset.
module tb_inst_mem_loader;

  localparam int ST_L = 0;  // loading: hold=1 done=0 err=0
  localparam int ST_D = 1;  // done:    hold=0 done=1 err=0
  localparam int ST_E = 2;  // error:   hold=1 done=0 err=1

  typedef struct {
    logic        rst;
    logic        rl;
    logic        vld;
    logic [7:0]  d;
    int          e_st;
    logic        e_wr;
    logic [31:0] e_addr;
    logic [31:0] e_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        reload = 1'b0;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];
  vec_t        vecs[$];

  inst_mem_loader #(.DEPTH_LOG2(8), .TIMEOUT_CYCLES(50)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .reload    (reload),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic r, input logic rl, input logic v, input logic [7:0] d);
    @(negedge clk);
    reset = r; reload = rl; rx_valid = v; rx_data = d;
    @(posedge clk);
    #1;
    cyc++;
    if (wr_en === 1'b1) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
      wc_q.push_back(cyc);
    end
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_status(input string name, input int st);
    check({name, " cpu_hold"},  32'(cpu_hold),  32'(st != ST_D));
    check({name, " load_done"}, 32'(load_done), 32'(st == ST_D));
    check({name, " load_err"},  32'(load_err),  32'(st == ST_E));
  endtask

  task automatic clear_log();
    wa_q.delete(); wd_q.delete(); wc_q.delete();
  endtask

  function automatic vec_t mk(input logic r, input logic rl, input logic v, input logic [7:0] d,
                              input int st, input logic w, input logic [31:0] a, input logic [31:0] dat);
    vec_t t;
    t.rst = r; t.rl = rl; t.vld = v; t.d = d;
    t.e_st = st; t.e_wr = w; t.e_addr = a; t.e_data = dat;
    return t;
  endfunction

  function automatic vec_t b(input logic [7:0] d, input int st);
    return mk(1'b0, 1'b0, 1'b1, d, st, 1'b0, 32'h0, 32'h0);
  endfunction

  function automatic vec_t bw(input logic [7:0] d, input logic [31:0] a, input logic [31:0] dat);
    return mk(1'b0, 1'b0, 1'b1, d, ST_L, 1'b1, a, dat);
  endfunction

  function automatic vec_t nop(input int st);
    return mk(1'b0, 1'b0, 1'b0, 8'h00, st, 1'b0, 32'h0, 32'h0);
  endfunction

  function automatic vec_t rl(input logic v, input int st);
    return mk(1'b0, 1'b1, v, 8'h00, st, 1'b0, 32'h0, 32'h0);
  endfunction

  initial begin
    // Two-word program 24100000, 03E00008.
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, ST_L, 1'b0, 32'h0, 32'h0));
    vecs.push_back(b(8'h00, ST_L)); vecs.push_back(b(8'h00, ST_L));
    vecs.push_back(b(8'h00, ST_L)); vecs.push_back(b(8'h02, ST_L));
    vecs.push_back(b(8'h24, ST_L)); vecs.push_back(b(8'h10, ST_L));
    vecs.push_back(b(8'h00, ST_L)); vecs.push_back(bw(8'h00, 32'h0, 32'h24100000));
    vecs.push_back(b(8'h03, ST_L)); vecs.push_back(b(8'hE0, ST_L));
    vecs.push_back(b(8'h00, ST_L)); vecs.push_back(bw(8'h08, 32'h4, 32'h03E00008));
    vecs.push_back(nop(ST_D));
    vecs.push_back(b(8'h55, ST_D));
    vecs.push_back(nop(ST_D));
    // Zero-length frame; a byte coinciding with reload is dropped.
    vecs.push_back(rl(1'b0, ST_L));
    vecs.push_back(rl(1'b1, ST_L));
    vecs.push_back(b(8'h00, ST_L)); vecs.push_back(b(8'h00, ST_L));
    vecs.push_back(b(8'h00, ST_L)); vecs.push_back(b(8'h00, ST_D));
    vecs.push_back(nop(ST_D));
    // Oversized count 257, then recovery with a one-word frame.
    vecs.push_back(rl(1'b0, ST_L));
    vecs.push_back(b(8'h00, ST_L)); vecs.push_back(b(8'h00, ST_L));
    vecs.push_back(b(8'h01, ST_L)); vecs.push_back(b(8'h01, ST_E));
    vecs.push_back(b(8'h00, ST_E)); vecs.push_back(nop(ST_E));
    vecs.push_back(rl(1'b0, ST_L));
    vecs.push_back(b(8'h00, ST_L)); vecs.push_back(b(8'h00, ST_L));
    vecs.push_back(b(8'h00, ST_L)); vecs.push_back(b(8'h01, ST_L));
    vecs.push_back(b(8'hAA, ST_L)); vecs.push_back(b(8'hBB, ST_L));
    vecs.push_back(b(8'hCC, ST_L)); vecs.push_back(bw(8'hDD, 32'h0, 32'hAABBCCDD));
    vecs.push_back(nop(ST_D));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].rl, vecs[i].vld, vecs[i].d);
      check($sformatf("v%0d wr_en", i), 32'(wr_en), 32'(vecs[i].e_wr));
      check_status($sformatf("v%0d", i), vecs[i].e_st);
      if (vecs[i].e_wr || vecs[i].rst) begin
        check($sformatf("v%0d wr_addr", i), wr_addr, vecs[i].e_addr);
        check($sformatf("v%0d wr_data", i), wr_data, vecs[i].e_data);
      end
    end

    // Timeout: idle LEN waits forever; a started frame errors 50 cycles after its last byte.
    step(1'b0, 1'b1, 1'b0, 8'h00);
    clear_log();
    repeat (100) idle();
    check_status("len idle", ST_L);
    send(8'h00); send(8'h00); send(8'h00); send(8'h01);
    send(8'h12); send(8'h34);
    repeat (49) idle();
    check("timeout t49 load_err", 32'(load_err), 32'd0);
    idle();
    check_status("timeout t50", ST_E);
    check("timeout writes", 32'(wa_q.size()), 32'd0);

    // Back-to-back stream of a 3-word frame.
    step(1'b0, 1'b1, 1'b0, 8'h00);
    clear_log();
    begin
      int start;
      start = cyc;
      send(8'h00); send(8'h00); send(8'h00); send(8'h03);
      for (int i = 1; i <= 12; i++) send(8'(i));
      idle();
      check_status("stream end", ST_D);
      check("stream writes", 32'(wa_q.size()), 32'd3);
      if (wa_q.size() == 3) begin
        check("stream w0 latency", 32'(wc_q[0]), 32'(start + 8));
        check("stream gap01", 32'(wc_q[1] - wc_q[0]), 32'd4);
        check("stream gap12", 32'(wc_q[2] - wc_q[1]), 32'd4);
        check("stream a0", wa_q[0], 32'h0);
        check("stream a1", wa_q[1], 32'h4);
        check("stream a2", wa_q[2], 32'h8);
        check("stream d0", wd_q[0], 32'h01020304);
        check("stream d1", wd_q[1], 32'h05060708);
        check("stream d2", wd_q[2], 32'h090A0B0C);
      end
    end

    // Reset after 5 of 8 data bytes; the partial word must not leak.
    step(1'b0, 1'b1, 1'b0, 8'h00);
    send(8'h00); send(8'h00); send(8'h00); send(8'h02);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check_status("mid reset", ST_L);
    check("mid reset wr_en", 32'(wr_en), 32'd0);
    clear_log();
    send(8'h00); send(8'h00); send(8'h00); send(8'h01);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    idle();
    check_status("after reset", ST_D);
    check("after reset writes", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() == 1) begin
      check("after reset addr", wa_q[0], 32'h0);
      check("after reset data", wd_q[0], 32'hDEADBEEF);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
